// File: rtl/compound_section_sequencer.sv
// compound_section_sequencer
// Two-section message generator. SECTION_A builds {mode, x, y} and pushes it into
// the FIFO of the current round-robin channel. SECTION_B publishes the message on
// the monitor port and advances x, mode and the channel pointer. Each channel
// drains its FIFO through a notify/sync handshake.
module compound_section_sequencer #(
  parameter int NUM_CH  = 2,
  parameter int X_WIDTH = 8,
  parameter int DEPTH   = 4,
  parameter int STEP    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  output logic [NUM_CH*(X_WIDTH+2)-1:0]   b_out_data,
  input  logic [NUM_CH-1:0]               b_out_sync,
  output logic [NUM_CH-1:0]               b_out_notify,
  output logic [X_WIDTH+1:0]              m_out_data,
  output logic                            m_out_notify
);

  localparam int W  = X_WIDTH + 2;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0]    LAST_CH  = CW'(NUM_CH - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [X_WIDTH:0] STEP_EXT = (X_WIDTH + 1)'(STEP);

  typedef enum logic [0:0] {
    SECTION_A = 1'b0,
    SECTION_B = 1'b1
  } state_t;

  // Message layout: mode in the MSB, x in the middle, parity of x in the LSB.
  function automatic logic [W-1:0] build_msg(input logic mode, input logic [X_WIDTH-1:0] x);
    build_msg = {mode, x, ^x};
  endfunction

  state_t               state_q, state_d;
  logic [X_WIDTH-1:0]   x_q, x_d;
  logic                 mode_q, mode_d;
  logic [CW-1:0]        ch_ptr_q, ch_ptr_d;
  logic [W-1:0]         latch_q, latch_d;
  logic [W-1:0]         m_data_q, m_data_d;
  logic                 m_notify_q, m_notify_d;

  logic [W-1:0]         mem_q    [NUM_CH][DEPTH];
  logic [W-1:0]         mem_d    [NUM_CH][DEPTH];
  logic [AW-1:0]        rd_ptr_q [NUM_CH];
  logic [AW-1:0]        rd_ptr_d [NUM_CH];
  logic [AW-1:0]        wr_ptr_q [NUM_CH];
  logic [AW-1:0]        wr_ptr_d [NUM_CH];
  logic [AW:0]          cnt_q    [NUM_CH];
  logic [AW:0]          cnt_d    [NUM_CH];

  logic [NUM_CH-1:0]    push_s;
  logic [NUM_CH-1:0]    pop_s;
  logic [W-1:0]         push_data_s;
  logic [X_WIDTH:0]     sum_s;

  // Section FSM: generate/push in A, publish and advance in B.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    mode_d      = mode_q;
    ch_ptr_d    = ch_ptr_q;
    latch_d     = latch_q;
    m_data_d    = m_data_q;
    m_notify_d  = 1'b0;
    push_s      = {NUM_CH{1'b0}};
    push_data_s = build_msg(mode_q, x_q);
    sum_s       = {1'b0, x_q} + STEP_EXT;
    case (state_q)
      SECTION_A: begin
        // Full check uses pre-edge occupancy; a same-edge pop does not help.
        if (en && (cnt_q[ch_ptr_q] != FULL_CNT)) begin
          push_s[ch_ptr_q] = 1'b1;
          latch_d          = push_data_s;
          state_d          = SECTION_B;
        end else begin
          state_d = SECTION_A;
        end
      end
      SECTION_B: begin
        m_data_d   = latch_q;
        m_notify_d = 1'b1;
        x_d        = sum_s[X_WIDTH-1:0];
        if (sum_s[X_WIDTH]) begin
          mode_d = ~mode_q;
        end else begin
          mode_d = mode_q;
        end
        if (ch_ptr_q == LAST_CH) begin
          ch_ptr_d = {CW{1'b0}};
        end else begin
          ch_ptr_d = ch_ptr_q + CW'(1);
        end
        state_d = SECTION_A;
      end
      default: begin
        state_d = SECTION_A;
      end
    endcase
  end

  // Per-channel FIFO bookkeeping: push from the FSM, pop on notify & sync.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    pop_s    = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      pop_s[i] = (cnt_q[i] != {(AW + 1){1'b0}}) && b_out_sync[i];
      if (push_s[i]) begin
        mem_d[i][wr_ptr_q[i]] = push_data_s;
        wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + (AW + 1)'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - (AW + 1)'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Channel outputs come straight from FIFO state so the head is stable while stalled.
  always_comb begin
    b_out_data   = {(NUM_CH * W){1'b0}};
    b_out_notify = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      b_out_notify[i]      = (cnt_q[i] != {(AW + 1){1'b0}});
      b_out_data[i*W +: W] = mem_q[i][rd_ptr_q[i]];
    end
  end

  assign m_out_data   = m_data_q;
  assign m_out_notify = m_notify_q;

  // State and datapath registers; reset discards all queued messages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SECTION_A;
      x_q        <= {X_WIDTH{1'b0}};
      mode_q     <= 1'b0;
      ch_ptr_q   <= {CW{1'b0}};
      latch_q    <= {W{1'b0}};
      m_data_q   <= {W{1'b0}};
      m_notify_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        rd_ptr_q[i] <= {AW{1'b0}};
        wr_ptr_q[i] <= {AW{1'b0}};
        cnt_q[i]    <= {(AW + 1){1'b0}};
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= {W{1'b0}};
        end
      end
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      mode_q     <= mode_d;
      ch_ptr_q   <= ch_ptr_d;
      latch_q    <= latch_d;
      m_data_q   <= m_data_d;
      m_notify_q <= m_notify_d;
      for (int i = 0; i < NUM_CH; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= mem_d[i][j];
        end
      end
    end
  end

endmodule

// File: tb/tb_compound_section_sequencer.sv
// Scoreboard bench for compound_section_sequencer (NUM_CH=2, X_WIDTH=8, DEPTH=4).
// A reference generator produces the expected message stream; each message is
// queued for the monitor port and for its round-robin channel and popped when
// the DUT presents it.
module tb_compound_section_sequencer;

  localparam int NUM_CH = 2;
  localparam int XW     = 8;
  localparam int DEPTH  = 4;
  localparam int W      = XW + 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [NUM_CH*W-1:0]   b_out_data;
  logic [NUM_CH-1:0]     b_out_sync;
  logic [NUM_CH-1:0]     b_out_notify;
  logic [W-1:0]          m_out_data;
  logic                  m_out_notify;

  always #5 clk = ~clk;

  compound_section_sequencer #(
    .NUM_CH (NUM_CH),
    .X_WIDTH(XW),
    .DEPTH  (DEPTH),
    .STEP   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .b_out_data  (b_out_data),
    .b_out_sync  (b_out_sync),
    .b_out_notify(b_out_notify),
    .m_out_data  (m_out_data),
    .m_out_notify(m_out_notify)
  );

  logic [W-1:0] exp_m[$];
  logic [W-1:0] exp_c0[$];
  logic [W-1:0] exp_c1[$];

  logic [XW-1:0] mx;
  logic          mmode;
  logic          mptr;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   pulses   = 0;
  logic prev_pulse = 1'b0;
  logic pulse_now  = 1'b0;
  logic [W-1:0] last_m = '0;
  logic seen_write = 1'b0;
  logic seen_read_after_write = 1'b0;

  function automatic logic [W-1:0] msg(input logic mode, input logic [XW-1:0] x);
    msg = {mode, x, ^x};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_m.delete();
    exp_c0.delete();
    exp_c1.delete();
    mx         = '0;
    mmode      = 1'b0;
    mptr       = 1'b0;
    prev_pulse = 1'b0;
  endtask

  // Produce the next expected message and queue it for monitor and its channel.
  task automatic gen_one();
    logic [W-1:0] m;
    logic [XW:0]  s;
    m = msg(mmode, mx);
    exp_m.push_back(m);
    if (mptr == 1'b0) exp_c0.push_back(m);
    else              exp_c1.push_back(m);
    s  = {1'b0, mx} + 9'd1;
    mx = s[XW-1:0];
    if (s[XW]) mmode = ~mmode;
    mptr = ~mptr;
  endtask

  // One clock: score channel transfers due at the coming edge, then score the monitor.
  task automatic cycle();
    logic [W-1:0] e;
    if (rst && b_out_notify[0] && b_out_sync[0]) begin
      for (int k = 0; k < 4 && exp_c0.size() == 0; k++) gen_one();
      e = exp_c0.pop_front();
      check_val("ch0_data", b_out_data[0*W +: W], e);
    end
    if (rst && b_out_notify[1] && b_out_sync[1]) begin
      for (int k = 0; k < 4 && exp_c1.size() == 0; k++) gen_one();
      e = exp_c1.pop_front();
      check_val("ch1_data", b_out_data[1*W +: W], e);
    end
    @(negedge clk);
    pulse_now = m_out_notify;
    if (m_out_notify) begin
      check_val("m_pulse_gap", prev_pulse, 1'b0);
      if (exp_m.size() == 0) gen_one();
      e = exp_m.pop_front();
      check_val("m_data", m_out_data, e);
      pulses++;
      last_m = m_out_data;
      if (m_out_data[W-1]) seen_write = 1'b1;
      else if (seen_write) seen_read_after_write = 1'b1;
    end
    prev_pulse = m_out_notify;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_pulse(input int budget);
    pulse_now = 1'b0;
    for (int k = 0; k < budget && !pulse_now; k++) cycle();
    if (!pulse_now) check_val("pulse_timeout", 32'd0, 32'd1);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset();
    #2 rst = 1'b0;
    #1;
    check_val("rst_b_notify", b_out_notify, '0);
    check_val("rst_m_notify", m_out_notify, 1'b0);
    check_val("rst_m_data", m_out_data, '0);
    model_reset();
    run(3);
  endtask

  initial begin
    int p0;
    rst        = 1'b0;
    en         = 1'b0;
    b_out_sync = 2'b00;
    model_reset();
    run(2);
    check_val("reset_b_notify", b_out_notify, '0);
    check_val("reset_m_notify", m_out_notify, 1'b0);
    check_val("reset_m_data", m_out_data, '0);

    // Free-running stream, both channels ready.
    rst = 1'b1; en = 1'b1; b_out_sync = 2'b11;
    run(8);
    check_val("rate_4_in_8", pulses, 32'd4);
    check_val("fourth_msg", last_m, msg(1'b0, 8'd3));
    run(5);

    // Mid-stream reset, then the first message must be x=0 read.
    apply_reset();
    p0 = pulses;
    rst = 1'b1;
    run(2);
    check_val("post_rst_pulses", pulses - p0, 32'd1);
    check_val("post_rst_first", last_m, 10'h000);
    run(10);

    // Channel 0 blocked: it fills with x=0,2,4,6 and the FSM stalls on it.
    apply_reset();
    p0 = pulses;
    b_out_sync = 2'b10;
    rst = 1'b1;
    run(40);
    check_val("stall_pulses", pulses - p0, 32'd8);
    check_val("stall_notify0", b_out_notify[0], 1'b1);
    check_val("stall_head0", b_out_data[W-1:0], msg(1'b0, 8'd0));
    run(10);
    check_val("stall_holds", pulses - p0, 32'd8);
    b_out_sync = 2'b11;
    run(60);
    check_val("stall_resumed", (pulses - p0) > 8, 1'b1);

    // Single-entry FIFO with push and pop on the same edge.
    apply_reset();
    p0 = pulses;
    b_out_sync = 2'b00;
    rst = 1'b1;
    run(4);
    check_val("pp_two_pulses", pulses - p0, 32'd2);
    b_out_sync = 2'b01;
    cycle();
    check_val("pp_occupancy", b_out_notify[0], 1'b1);
    check_val("pp_new_head", b_out_data[W-1:0], msg(1'b0, 8'd2));
    b_out_sync = 2'b11;
    run(30);
    en = 1'b0;
    run(10);
    check_val("pp_drained_m", exp_m.size(), 32'd0);
    check_val("pp_drained_c0", exp_c0.size(), 32'd0);
    check_val("pp_drained_c1", exp_c1.size(), 32'd0);

    // Drop en while in SECTION_B: the pulse still occurs, then generation halts.
    en = 1'b1;
    wait_pulse(20);
    cycle();
    en = 1'b0;
    p0 = pulses;
    cycle();
    check_val("enb_pulse", pulses - p0, 32'd1);
    run(10);
    check_val("enb_hold", pulses - p0, 32'd1);
    check_val("enb_idle_notify", b_out_notify, '0);
    en = 1'b1;

    // Long run across two x wraps; the mode toggles at each one.
    run(1100);
    check_val("wrap_write_seen", seen_write, 1'b1);
    check_val("wrap_read_again", seen_read_after_write, 1'b1);

    en = 1'b0;
    run(12);
    check_val("end_notify", b_out_notify, '0);
    check_val("end_q_m", exp_m.size(), 32'd0);
    check_val("end_q_c0", exp_c0.size(), 32'd0);
    check_val("end_q_c1", exp_c1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
